// File: rtl/addsub_iter_if.sv
// Request/response bundle for the iterative adder/subtractor.
// The requester drives operands and out_ready; the engine drives the rest.
interface addsub_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             sign;
  logic             zero;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result,
    input  carry, overflow, sign, zero
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result,
    output carry, overflow, sign, zero
  );
endinterface

// File: rtl/addsub_iter.sv
// Multi-cycle add/sub, CHUNK bits per clock, LSB chunk first.
// Subtract runs as a + ~b + c0; flags register on the final chunk.
module addsub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_iter_if.slave bus
);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             sub_q, sub_d;
  logic             zacc_q, zacc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] a_i, b_i, r_i;
  logic             c_nx;
  logic             c_msb;

  assign a_i = a_q[CHUNK-1:0];
  assign b_i = b_q[CHUNK-1:0];
  assign {c_nx, r_i} = {1'b0, a_i} + {1'b0, b_i}
                     + {{CHUNK{1'b0}}, c_q};
  // Carry into the top bit recovered from its sum bit.
  assign c_msb = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ r_i[CHUNK-1];

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;
  assign bus.sign      = sign_q;
  assign bus.zero      = zero_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus chunk datapath.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sub_d   = sub_q;
    zacc_d  = zacc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.op[0] ? ~bus.b : bus.b;
          sub_d   = bus.op[0];
          c_d     = bus.op[1] ? (bus.cin ^ bus.op[0])
                              : bus.op[0];
          cnt_d   = '0;
          zacc_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> CHUNK;
        b_d    = b_q >> CHUNK;
        acc_d  = (acc_q >> CHUNK)
               | (WIDTH'(r_i) << (WIDTH - CHUNK));
        c_d    = c_nx;
        zacc_d = zacc_q & (r_i == '0);
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          res_d   = acc_d;
          carry_d = c_nx ^ sub_q;
          ovf_d   = c_msb ^ c_nx;
          sign_d  = acc_d[WIDTH-1];
          zero_d  = zacc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      sub_q   <= 1'b0;
      zacc_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sub_q   <= sub_d;
      zacc_q  <= zacc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: doc/addsub_iter.md
Name: addsub_iter

Overview:
- Parameterised, multi-cycle adder/subtractor with registered flags and a valid/ready handshake on both sides.
- Processes the operands CHUNK bits per cycle, LSB chunk first, and keeps the carry in an internal register between chunks.
- Generalises the team's 32-bit combinational adder:
  - configurable width and chunk size;
  - true subtract with borrow semantics;
  - add-with-carry and subtract-with-borrow modes;
  - overflow flag that is correct for both add and subtract.
- Sits between the ALU operand registers and the writeback/flag register in the datapath.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH. STEPS = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  request valid; a, b, op, cin are sampled when in_valid && in_ready.
in_ready  output  1  block can accept a request.
op  input  2  00 ADD (a+b), 01 SUB (a-b), 10 ADC (a+b+cin), 11 SBB (a-b-cin).
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry/borrow in; ignored for ADD/SUB.
out_valid  output  1  result and flags valid.
out_ready  input  1  consumer accepts the result when out_valid && out_ready.
result  output  WIDTH  sum/difference modulo 2^WIDTH.
carry  output  1  ADD/ADC: carry out of the MSB. SUB/SBB: borrow, i.e. NOT of the internal carry out.
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB (internal carries).
sign  output  1  result[WIDTH-1].
zero  output  1  1 iff result == 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE;
  - in_ready = 1, out_valid = 0;
  - result = 0, carry = 0, overflow = 0, sign = 0, zero = 0;
  - internal chunk counter and carry register cleared.
- Reset asserted mid-operation aborts the request; no partial result is ever presented.
- Subtraction is computed internally as a + ~b + c0:
  - SUB: c0 = 1;
  - SBB: c0 = ~cin;
  - ADD: c0 = 0;
  - ADC: c0 = cin.
- Per-chunk step i (i = 0..STEPS-1):
  - {c_next, r_chunk} = a_i + b'_i + c;
  - r_chunk is written to result bits [i*CHUNK +: CHUNK];
  - c <= c_next;
  - zero accumulator &= (r_chunk == 0).
- On the last chunk, also capture the carry into bit WIDTH-1 for overflow. This carry is independent of the chunk boundary.
- States:
  - IDLE:
    - in_ready = 1;
    - handshake edge latches a, b (inverted for SUB/SBB), op, c0;
    - clears counter, sets zero accumulator to 1;
    - goes to RUN.
  - RUN:
    - in_ready = 0, out_valid = 0;
    - one chunk per clock edge;
    - after the edge processing chunk STEPS-1: flags are registered, out_valid = 1, go to DONE.
  - DONE:
    - out_valid = 1 and in_ready = 0;
    - result and flags held stable while waiting;
    - edge with out_ready = 1: go to IDLE, out_valid = 0.
    - result and flags keep their last values after the handshake; they are only changed by the next request's final step or by reset.
- Latency: request handshake at edge k -> out_valid high after edge k+STEPS. Throughput is one request per STEPS+2 cycles minimum.
- No new request is accepted in the same cycle as the output handshake (in_ready is low in DONE).
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- CHUNK == WIDTH (STEPS = 1) must work: one RUN cycle.
- CHUNK == 1 must work: bit-serial operation.
- Inputs a, b, op, cin may change freely after acceptance; only latched copies are used.

Test Plan:
- WIDTH=32, CHUNK=8, ADD 0x7FFFFFFF+0x00000001:
  - out_valid exactly 4 edges after the accept edge;
  - result 0x80000000, carry 0, overflow 1, sign 1, zero 0.
- SUB 5-5:
  - result 0, zero 1, carry 0, overflow 0.
- SUB 0-1:
  - result 0xFFFFFFFF, carry (borrow) 1, sign 1, overflow 0.
- SUB 0x80000000-1:
  - result 0x7FFFFFFF, overflow 1, carry 0.
- ADC 0xFFFFFFFF+0 with cin=1:
  - result 0, carry 1, zero 1.
- SBB 0x10-0x0F with cin=1:
  - result 0, zero 1, carry 0.
- Backpressure and reset, with out_ready held low 5 cycles:
  - out_valid, result and flags stay stable, and in_ready stays 0;
  - out_ready pulse returns to IDLE with out_valid 0 next cycle.
  - Separately, assert rst_n low in the middle of RUN: all outputs 0 and in_ready 1 immediately (asynchronously).
- Parameter sweep (WIDTH, CHUNK) = (32,32), (32,1), (16,4):
  - random ops against a reference model;
  - latency equals STEPS and all flags match.
